// File: rtl/poly_note_player_pkg.sv
// Shared constants for the polyphonic note player: phase width, the note-to-step
// table and the phase-to-triangle conversion.
package poly_note_player_pkg;

  localparam int PHASE_W      = 20;
  localparam int NOTE_TABLE_N = 256;  // covers NOTE_W up to 8

  // Top-octave phase steps for the twelve semitones.
  function automatic logic [PHASE_W-1:0] semitone_step(input int k);
    case (k)
      0:       return 20'd262144;
      1:       return 20'd277731;
      2:       return 20'd294247;
      3:       return 20'd311744;
      4:       return 20'd330281;
      5:       return 20'd349920;
      6:       return 20'd370727;
      7:       return 20'd392772;
      8:       return 20'd416128;
      9:       return 20'd440871;
      10:      return 20'd467088;
      default: return 20'd494862;
    endcase
  endfunction

  // Note 0 is a rest; notes 1..12 are the lowest octave, each octave up doubles.
  function automatic logic [PHASE_W*NOTE_TABLE_N-1:0] build_note_step();
    logic [PHASE_W*NOTE_TABLE_N-1:0] t;
    t = '0;
    for (int n = 1; n < NOTE_TABLE_N; n++) begin
      int oct;
      int sh;
      oct = (n - 1) / 12;
      sh  = (oct >= 5) ? 0 : 5 - oct;
      t[n*PHASE_W +: PHASE_W] = semitone_step((n - 1) % 12) >> sh;
    end
    return t;
  endfunction

  localparam logic [PHASE_W*NOTE_TABLE_N-1:0] NOTE_STEP = build_note_step();

  // Rises from -32768 to 32766 over the first half cycle, falls back over the second.
  function automatic logic signed [15:0] triangle(input logic [15:0] p);
    logic [15:0] up;
    up = {p[14:0], 1'b0};
    if (!p[15]) return signed'(up - 16'h8000);
    else        return signed'(16'h7fff - up);
  endfunction

endpackage

// File: rtl/poly_note_player_voice.sv
// One voice: beat-driven duration counter, phase accumulator and triangle output.
module note_voice
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load,
  input  logic [NOTE_W-1:0]          note,
  input  logic [DUR_W-1:0]           duration,
  input  logic                       beat,
  input  logic                       advance,
  output logic                       busy,
  output logic                       done,
  output logic signed [SAMPLE_W-1:0] wave
);

  logic [DUR_W-1:0]   count_reg;
  logic [PHASE_W-1:0] step_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [PHASE_W-1:0] step_lut;
  logic signed [15:0] tri16;
  logic signed [SAMPLE_W-1:0] tri_scaled;

  always_comb begin
    step_lut = NOTE_STEP[int'(note)*PHASE_W +: PHASE_W];
  end

  // A load always wins over a same-cycle beat or phase advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      step_reg  <= '0;
      phase_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load && duration != '0) begin
        count_reg <= duration;
        step_reg  <= step_lut;
        phase_reg <= '0;
        busy_reg  <= 1'b1;
      end else if (play_enable && busy_reg) begin
        if (beat) begin
          count_reg <= count_reg - 1'b1;
          if (count_reg == DUR_W'(1)) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end
        if (advance) phase_reg <= phase_reg + step_reg;
      end
    end
  end

  assign tri16 = triangle(phase_reg[PHASE_W-1:4]);

  generate
    if (SAMPLE_W > 16) begin : g_wide
      assign tri_scaled = {tri16, {(SAMPLE_W-16){1'b0}}};
    end else if (SAMPLE_W == 16) begin : g_exact
      assign tri_scaled = tri16;
    end else begin : g_narrow
      assign tri_scaled = tri16[15 -: SAMPLE_W];
    end
  endgenerate

  // A rest (zero step) is silent rather than a constant negative level.
  assign wave = (busy_reg && step_reg != '0) ? tri_scaled : '0;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic triangle-wave note player with a registered mixed output.
// Define POLY_NOTE_PLAYER_SATURATE_EN to clamp the mix instead of scaling it down.
module poly_note_player
  import poly_note_player_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  input  logic [$clog2(VOICES)-1:0]  voice_sel,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic [VOICES-1:0]          done_with_note,
  output logic [VOICES-1:0]          voice_busy,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);

  localparam int SEL_W = $clog2(VOICES);
  localparam int MIX_W = SAMPLE_W + SEL_W;

  logic signed [SAMPLE_W-1:0] wave [VOICES];
  logic signed [MIX_W-1:0]    mix;
  logic signed [SAMPLE_W-1:0] sample_next;

  generate
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
      note_voice #(
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .SAMPLE_W (SAMPLE_W)
      ) u_voice (
        .clk         (clk),
        .reset       (reset),
        .play_enable (play_enable),
        .load        (load_new_note && voice_sel == SEL_W'(gi)),
        .note        (note_to_load),
        .duration    (duration_to_load),
        .beat        (beat),
        .advance     (generate_next_sample),
        .busy        (voice_busy[gi]),
        .done        (done_with_note[gi]),
        .wave        (wave[gi])
      );
    end
  endgenerate

  always_comb begin
    mix = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix = mix + {{SEL_W{wave[v][SAMPLE_W-1]}}, wave[v]};
    end
  end

`ifdef POLY_NOTE_PLAYER_SATURATE_EN
  localparam logic signed [MIX_W-1:0] SAT_MAX = signed'({{(SEL_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (mix > SAT_MAX)      sample_next = SAT_MAX[SAMPLE_W-1:0];
    else if (mix < SAT_MIN) sample_next = SAT_MIN[SAMPLE_W-1:0];
    else                    sample_next = SAMPLE_W'(mix);
  end
`else
  always_comb begin
    sample_next = SAMPLE_W'(mix >>> SEL_W);
  end
`endif

  // The sample reflects voice phases as they stood when the request arrived.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= generate_next_sample;
      if (generate_next_sample) sample_out <= play_enable ? sample_next : '0;
    end
  end

endmodule
